execute_stage_md: RTL and testbench
===================================

# execute_stage_md

Parametrised RV32IM/RV64IM execute stage sitting between the ID/EX and EX/MEM pipeline registers. It keeps the single-cycle ALU, branch-resolve and forwarding paths, and adds an M-extension multiply/divide unit. MUL ops take 2 cycles; DIV/REM ops run an iterative radix-2 divide. While a multiply/divide is in progress, `stallMD` freezes F/D/E and bubbles MEM through the hazard unit.

## Interface
Parameters:
- `XLEN`, default 32: datapath width; legal values 32 or 64.
- `CNT_W`, default $clog2(XLEN)+1: width of the divide iteration counter.

Ports:
- `clk` in 1: rising-edge clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `pcE` in XLEN: PC of the instruction in EX.
- `rd1E`, `rd2E` in XLEN: register operands from ID/EX.
- `extImmE` in XLEN: sign-extended immediate.
- `aluControlE` in 4: ALU op or branch type. Branch types: BEQ 0001, BNE 1100, BLT 0101, BGE 1001, BLTU 0110, BGEU 1010.
- `aluSrcE` in 1: 1 selects `extImmE` as ALU operand B.
- `branchE` in 1: the instruction is a conditional branch.
- `mdValidE` in 1: the instruction is an M-extension op.
- `mdOpE` in 3: funct3 of the M op. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `flushE` in 1: the EX instruction is squashed.
- `forwardAE`, `forwardBE` in 2: operand source select. 00 register file, 10 `aluResultM`, 01 `resultW`, 11 register file.
- `aluResultM`, `resultW` in XLEN: forwarded values.
- `aluResultE` out XLEN: ALU result, or M-op result in the DONE cycle.
- `writeDataE` out XLEN: forwarded rs2, used as store data.
- `branchTargetE` out XLEN: `pcE + extImmE`, modulo 2^XLEN.
- `branchTakenE` out 1: branch condition is true and `branchE` is high.
- `stallMD` out 1: hold F/D/E and bubble MEM.
- `mdBusy` out 1: the FSM is not IDLE; for debug and performance counters.

## Operation
- Forwarding muxes produce `srcA` and `tempB`. `writeDataE = tempB`. `srcB = aluSrcE ? extImmE : tempB`.
- Branch compare uses `srcA` against `tempB`. Signed compares use XLEN-bit two's complement. Unlisted `aluControlE` codes give not-taken.
- FSM states are IDLE, MUL, DIV, DONE. Reset state is IDLE.
- IDLE with `mdValidE` and no `flushE`:
  - register `srcA`, `tempB` and `mdOpE` into `opA`, `opB`, `op`; operands must be held because forwarding sources vanish during the stall;
  - go to MUL if `op[2]=0`, otherwise go to DIV with counter = XLEN.
- MUL: compute the 2·XLEN-bit product with signedness per op, register the selected half, go to DONE.
  - MUL takes the low half. MULH, MULHSU and MULHU take the high half.
- DIV: one restoring shift-subtract step per cycle on magnitudes. The counter decrements each step. At counter 1, apply sign fixups and go to DONE.
- DIV special cases, which must match the ISA:
  - divide by zero gives quotient all-ones and remainder = dividend;
  - signed overflow (most-negative ÷ −1) gives quotient = dividend and remainder 0.
- DONE:
  - drive the M result on `aluResultE`;
  - do not start a new op in this cycle, even though `mdValidE` is still high for the same instruction;
  - go to IDLE.
- `flushE` in any state except IDLE sends the FSM to IDLE next cycle. No result is produced.
- `rst` asserted mid-operation sends the FSM to IDLE immediately; the result register clears.

## Timing
- ALU, branch and forwarding paths are combinational, with zero added latency.
- `stallMD = (IDLE & mdValidE & ~flushE) | MUL | DIV`. It is low in DONE, so the instruction retires at the end of the DONE cycle.
- MUL-class latency: accept at T, DONE at T+1, 2 cycles total.
- DIV-class latency: accept at T, DIV for T+1..T+XLEN, DONE at T+XLEN+1, XLEN+2 cycles total.
- Back-to-back M ops: the second op enters EX at T_done+1, finds IDLE, and starts at once.
- Reset values:
  - `stallMD`, `mdBusy` = 0;
  - internal result, `opA`, `opB` and counter = 0;
  - combinational outputs follow their inputs.

## Configuration
- `EX_EARLY_DIV_EN` defined: divide-by-zero and signed overflow are detected at accept. The FSM goes directly to DONE, with the same 2-cycle latency as MUL.
- `EX_EARLY_DIV_EN` undefined: these cases run the full XLEN iterations, then fix up the result. Result values are identical either way.

## Structure
- Package `ex_pkg` holds:
  - `md_op_t` enum, with the funct3 encodings above;
  - `md_state_t` enum;
  - branch `aluControl` code localparams;
  - forward-select localparams.
- Sub-module `muldiv_unit`, instantiated once, owns the FSM, operand registers, multiplier and divider. Ports: `clk`, `rst`, `start`, `flush`, `op`, `a`, `b`, `busy`, `done`, `result`.
- The ALU is reused unchanged.

## Test plan
- Forwarding, XLEN=32: `forwardAE=10`, `aluResultM=5`, `rd2E=3`, ADD → `aluResultE=8`. `forwardBE=01` with `resultW=7` → `writeDataE=7`.
- Branches: BLT with `srcA=0xFFFFFFFF`, `tempB=1` → taken. BLTU with the same operands → not taken. `branchE=0` → not taken.
- MUL: MULH with 0x80000000 × 0x80000000 → 0x40000000. `stallMD` is high exactly 1 cycle; the result appears in cycle T+1.
- DIV: −7 DIV 2 gives −3; REM gives −1. `stallMD` is high for 33 cycles. Forwarding inputs are scrambled during the stall and the result is still correct.
- Special cases: DIV 5÷0 → 0xFFFFFFFF; REM 5÷0 → 5; 0x80000000 DIV −1 → 0x80000000. Latency is 2 cycles with `EX_EARLY_DIV_EN`, 34 without.
- Abort: `flushE` at T+10 of a DIV → `stallMD` drops next cycle and the FSM is IDLE. `rst` pulse mid-DIV → `stallMD=0` asynchronously. A following MUL completes normally.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared types and encodings for the execute stage.
//   md_op_t    : M-extension funct3 encodings
//   md_state_t : multiply/divide FSM states
//   BR_*       : branch-type codes carried on aluControl
//   ALU_*      : ALU operation codes carried on aluControl
//   FWD_*      : forwarding select encodings
package ex_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_t;

  // S_MUL is part of the state encoding, but the product is registered
  // directly from the accept cycle, so the FSM never sits in S_MUL.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } md_state_t;

  localparam logic [3:0] BR_BEQ  = 4'b0001;
  localparam logic [3:0] BR_BNE  = 4'b1100;
  localparam logic [3:0] BR_BLT  = 4'b0101;
  localparam logic [3:0] BR_BGE  = 4'b1001;
  localparam logic [3:0] BR_BLTU = 4'b0110;
  localparam logic [3:0] BR_BGEU = 4'b1010;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: M-extension multiply / iterative radix-2 restoring divide.
// Optional feature macro: EX_EARLY_DIV_EN (divide-by-zero and signed
// overflow resolved at accept, finishing in 2 cycles like a multiply).
// Ports:
//   clk, rst      clock, async active-high reset
//   start         request to accept op/a/b (only honoured in IDLE)
//   flush         abort any in-flight op
//   op[2:0]       funct3 of the M op
//   a, b          operands (captured at accept)
//   busy          FSM not IDLE
//   done          FSM in DONE; result is valid
//   result        registered M result
module muldiv_unit
  import ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t        state_reg, state_next;
  logic [2:0]       op_reg, op_next;
  logic [XLEN-1:0]  opa_reg, opa_next, opb_reg, opb_next;
  logic [XLEN-1:0]  rem_reg, rem_next, quo_reg, quo_next, dvs_reg, dvs_next;
  logic [XLEN-1:0]  result_reg, result_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

  function automatic logic div_special(input logic [2:0] o, input logic [XLEN-1:0] x,
                                       input logic [XLEN-1:0] y);
    return (y == '0) || (!o[0] && x == MOST_NEG && y == '1);
  endfunction

  // ISA-mandated results: x/0 -> q=all ones, r=x; MIN/-1 -> q=MIN, r=0.
  function automatic logic [XLEN-1:0] special_res(input logic [2:0] o, input logic [XLEN-1:0] x,
                                                  input logic [XLEN-1:0] y);
    if (y == '0) return o[1] ? x : '1;
    return o[1] ? '0 : x;
  endfunction

  // Operands are sign- or zero-extended to 2*XLEN+2 bits so a plain unsigned
  // multiply yields the correct low bits of the signed/mixed product.
  function automatic logic [XLEN-1:0] mul_res(input logic [2:0] o, input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y);
    logic                sx, sy;
    logic [2*XLEN+1:0]   ex, ey, p;
    sx = (o == MD_MULH || o == MD_MULHSU) && x[XLEN-1];
    sy = (o == MD_MULH) && y[XLEN-1];
    ex = {{(XLEN+2){sx}}, x};
    ey = {{(XLEN+2){sy}}, y};
    p  = ex * ey;
    return (o == MD_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // One restoring step on the shifted partial remainder.
  logic [XLEN:0]   rsh;
  logic            ge;
  logic [XLEN-1:0] rem_step, quo_step, q_fix, r_fix, div_res;
  logic            neg_q, neg_r, early;

  always_comb begin
    rsh      = {rem_reg, quo_reg[XLEN-1]};
    ge       = rsh >= {1'b0, dvs_reg};
    rem_step = ge ? (rsh[XLEN-1:0] - dvs_reg) : rsh[XLEN-1:0];
    quo_step = {quo_reg[XLEN-2:0], ge};
    neg_q    = !op_reg[0] && (opa_reg[XLEN-1] ^ opb_reg[XLEN-1]);
    neg_r    = !op_reg[0] && opa_reg[XLEN-1];
    q_fix    = neg_q ? -quo_step : quo_step;
    r_fix    = neg_r ? -rem_step : rem_step;
    div_res  = div_special(op_reg, opa_reg, opb_reg) ? special_res(op_reg, opa_reg, opb_reg)
                                                     : (op_reg[1] ? r_fix : q_fix);
  end

`ifdef EX_EARLY_DIV_EN
  assign early = div_special(op, a, b);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    opa_next    = opa_reg;
    opb_next    = opb_reg;
    rem_next    = rem_reg;
    quo_next    = quo_reg;
    dvs_next    = dvs_reg;
    cnt_next    = cnt_reg;
    result_next = result_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          op_next  = op;
          opa_next = a;
          opb_next = b;
          if (!op[2] || early) begin
            result_next = op[2] ? special_res(op, a, b) : mul_res(op, a, b);
            state_next  = S_DONE;
          end else begin
            rem_next   = '0;
            quo_next   = mag(a, !op[0]);
            dvs_next   = mag(b, !op[0]);
            cnt_next   = CNT_W'(XLEN);
            state_next = S_DIV;
          end
        end
      end
      S_DIV: begin
        rem_next = rem_step;
        quo_next = quo_step;
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          result_next = div_res;
          state_next  = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush && state_reg != S_IDLE) state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg     <= '0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      dvs_reg    <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
    end else begin
      op_reg     <= op_next;
      opa_reg    <= opa_next;
      opb_reg    <= opb_next;
      rem_reg    <= rem_next;
      quo_reg    <= quo_next;
      dvs_reg    <= dvs_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
    end
  end

  assign busy   = (state_reg != S_IDLE);
  assign done   = (state_reg == S_DONE);
  assign result = result_reg;

endmodule

// File: rtl/execute_stage_md.sv
// execute_stage_md: RV32IM/RV64IM execute stage (ALU, branch resolve,
// forwarding) with an M-extension multiply/divide unit.
// Optional feature macro: EX_EARLY_DIV_EN (handled inside muldiv_unit).
// Ports:
//   clk, rst                 clock, async active-high reset
//   pcE, rd1E, rd2E, extImmE PC, register operands, immediate
//   aluControlE              ALU op or branch type
//   aluSrcE, branchE         operand-B select, conditional-branch flag
//   mdValidE, mdOpE          M-op valid and funct3
//   flushE                   squash the EX instruction
//   forwardAE/BE             forwarding selects; aluResultM, resultW sources
//   aluResultE               ALU result, or M result in the DONE cycle
//   writeDataE               forwarded rs2 (store data)
//   branchTargetE/TakenE     branch target and decision
//   stallMD                  hold F/D/E and bubble MEM
//   mdBusy                   multiply/divide FSM not IDLE
module execute_stage_md
  import ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pcE,
  input  logic [XLEN-1:0] rd1E,
  input  logic [XLEN-1:0] rd2E,
  input  logic [XLEN-1:0] extImmE,
  input  logic [3:0]      aluControlE,
  input  logic            aluSrcE,
  input  logic            branchE,
  input  logic            mdValidE,
  input  logic [2:0]      mdOpE,
  input  logic            flushE,
  input  logic [1:0]      forwardAE,
  input  logic [1:0]      forwardBE,
  input  logic [XLEN-1:0] aluResultM,
  input  logic [XLEN-1:0] resultW,
  output logic [XLEN-1:0] aluResultE,
  output logic [XLEN-1:0] writeDataE,
  output logic [XLEN-1:0] branchTargetE,
  output logic            branchTakenE,
  output logic            stallMD,
  output logic            mdBusy
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] src_a, temp_b, src_b, alu_out, md_result;
  logic [SHW-1:0]  shamt;
  logic            md_busy, md_done, md_start, br_cond;

  always_comb begin
    case (forwardAE)
      FWD_MEM: src_a = aluResultM;
      FWD_WB:  src_a = resultW;
      default: src_a = rd1E;
    endcase
    case (forwardBE)
      FWD_MEM: temp_b = aluResultM;
      FWD_WB:  temp_b = resultW;
      default: temp_b = rd2E;
    endcase
  end

  assign src_b      = aluSrcE ? extImmE : temp_b;
  assign writeDataE = temp_b;
  assign shamt      = src_b[SHW-1:0];

  always_comb begin
    case (aluControlE)
      ALU_ADD:  alu_out = src_a + src_b;
      ALU_SUB:  alu_out = src_a - src_b;
      ALU_SLL:  alu_out = src_a << shamt;
      ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_XOR:  alu_out = src_a ^ src_b;
      ALU_SRL:  alu_out = src_a >> shamt;
      ALU_SRA:  alu_out = $signed(src_a) >>> shamt;
      ALU_OR:   alu_out = src_a | src_b;
      ALU_AND:  alu_out = src_a & src_b;
      default:  alu_out = '0;
    endcase
  end

  // Branches compare the forwarded rs1/rs2 values, never the immediate.
  always_comb begin
    case (aluControlE)
      BR_BEQ:  br_cond = (src_a == temp_b);
      BR_BNE:  br_cond = (src_a != temp_b);
      BR_BLT:  br_cond = ($signed(src_a) < $signed(temp_b));
      BR_BGE:  br_cond = ($signed(src_a) >= $signed(temp_b));
      BR_BLTU: br_cond = (src_a < temp_b);
      BR_BGEU: br_cond = (src_a >= temp_b);
      default: br_cond = 1'b0;
    endcase
  end

  assign branchTakenE  = branchE & br_cond;
  assign branchTargetE = pcE + extImmE;

  assign md_start = mdValidE & ~flushE;

  muldiv_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .flush  (flushE),
    .op     (mdOpE),
    .a      (src_a),
    .b      (temp_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // busy & ~done is exactly the MUL/DIV states; DONE lets the op retire.
  assign stallMD    = (~md_busy & md_start) | (md_busy & ~md_done);
  assign mdBusy     = md_busy;
  assign aluResultE = md_done ? md_result : alu_out;

endmodule

// File: tb/tb_execute_stage_md.sv
// tb_execute_stage_md: directed self-checking bench for execute_stage_md
// (XLEN=32). M-op expected results go through a scoreboard queue.
module tb_execute_stage_md;
  import ex_pkg::*;

  localparam int XLEN = 32;
`ifdef EX_EARLY_DIV_EN
  localparam int SPECIAL_STALL = 1;
`else
  localparam int SPECIAL_STALL = XLEN + 1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] pcE, rd1E, rd2E, extImmE, aluResultM, resultW;
  logic [3:0]      aluControlE;
  logic            aluSrcE, branchE, mdValidE, flushE;
  logic [2:0]      mdOpE;
  logic [1:0]      forwardAE, forwardBE;
  logic [XLEN-1:0] aluResultE, writeDataE, branchTargetE;
  logic            branchTakenE, stallMD, mdBusy;

  always #5 clk = ~clk;

  execute_stage_md #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .pcE(pcE), .rd1E(rd1E), .rd2E(rd2E), .extImmE(extImmE),
    .aluControlE(aluControlE), .aluSrcE(aluSrcE), .branchE(branchE),
    .mdValidE(mdValidE), .mdOpE(mdOpE), .flushE(flushE),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .aluResultM(aluResultM), .resultW(resultW),
    .aluResultE(aluResultE), .writeDataE(writeDataE),
    .branchTargetE(branchTargetE), .branchTakenE(branchTakenE),
    .stallMD(stallMD), .mdBusy(mdBusy)
  );

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one M op, scramble forwarding sources while stalled, then compare
  // the DONE-cycle result and the number of stalled cycles.
  task automatic md_op(input string tag, input logic [2:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int exp_stall);
    int cycles;
    int stalls;
    @(negedge clk);
    rd1E = a; rd2E = b; forwardAE = FWD_RF; forwardBE = FWD_RF;
    mdOpE = op; mdValidE = 1'b1; flushE = 1'b0; aluControlE = ALU_ADD; aluSrcE = 1'b0;
    exp_q.push_back(exp);
    #1;
    cycles = 0;
    stalls = 0;
    while (!(mdBusy && !stallMD) && cycles < 100) begin
      if (stallMD) stalls++;
      cycles++;
      @(negedge clk);
      rd1E = $urandom; rd2E = $urandom; aluResultM = $urandom; resultW = $urandom;
      forwardAE = 2'($urandom_range(0, 3)); forwardBE = 2'($urandom_range(0, 3));
      #1;
    end
    check({tag, " done_seen"}, XLEN'(mdBusy && !stallMD), XLEN'(1));
    check({tag, " result"}, aluResultE, exp_q.pop_front());
    check({tag, " stall_cycles"}, XLEN'(stalls), XLEN'(exp_stall));
    $display("md %s op=%0d a=0x%h b=0x%h result=0x%h stalls=%0d", tag, op, a, b, aluResultE, stalls);
  endtask

  task automatic go_idle();
    @(negedge clk);
    mdValidE = 1'b0; flushE = 1'b0; forwardAE = FWD_RF; forwardBE = FWD_RF;
  endtask

  initial begin
    rst = 1'b1;
    pcE = '0; rd1E = 32'd10; rd2E = 32'd20; extImmE = '0; aluResultM = '0; resultW = '0;
    aluControlE = ALU_ADD; aluSrcE = 1'b0; branchE = 1'b0; mdValidE = 1'b0; flushE = 1'b0;
    mdOpE = '0; forwardAE = FWD_RF; forwardBE = FWD_RF;
    #12;
    check("reset stallMD", XLEN'(stallMD), '0);
    check("reset mdBusy", XLEN'(mdBusy), '0);
    check("reset alu passthrough", aluResultE, 32'd30);
    @(negedge clk); rst = 1'b0;

    // Forwarding and ALU
    @(negedge clk);
    forwardAE = FWD_MEM; aluResultM = 32'd5; rd2E = 32'd3; forwardBE = FWD_RF; #1;
    check("fwd A from MEM add", aluResultE, 32'd8);
    @(negedge clk); forwardBE = FWD_WB; resultW = 32'd7; #1;
    check("fwd B from WB store", writeDataE, 32'd7);
    check("fwd B from WB add", aluResultE, 32'd12);
    @(negedge clk); forwardAE = FWD_RF; forwardBE = FWD_RF; rd1E = 32'd100; rd2E = 32'd1;
    aluSrcE = 1'b1; extImmE = 32'd40; aluControlE = ALU_SUB; #1;
    check("imm sub", aluResultE, 32'd60);
    check("store data ignores imm", writeDataE, 32'd1);
    @(negedge clk); pcE = 32'hFFFF_FFFC; extImmE = 32'd8; #1;
    check("branch target wrap", branchTargetE, 32'd4);

    // Branches
    @(negedge clk); aluSrcE = 1'b0; branchE = 1'b1; rd1E = 32'hFFFF_FFFF; rd2E = 32'd1;
    aluControlE = BR_BLT; #1;
    check("BLT -1<1", XLEN'(branchTakenE), XLEN'(1));
    @(negedge clk); aluControlE = BR_BLTU; #1;
    check("BLTU max<1", XLEN'(branchTakenE), XLEN'(0));
    @(negedge clk); aluControlE = BR_BGEU; #1;
    check("BGEU max>=1", XLEN'(branchTakenE), XLEN'(1));
    @(negedge clk); aluControlE = BR_BGE; #1;
    check("BGE -1>=1", XLEN'(branchTakenE), XLEN'(0));
    @(negedge clk); aluControlE = BR_BEQ; rd2E = 32'hFFFF_FFFF; #1;
    check("BEQ equal", XLEN'(branchTakenE), XLEN'(1));
    @(negedge clk); aluControlE = BR_BNE; #1;
    check("BNE equal", XLEN'(branchTakenE), XLEN'(0));
    @(negedge clk); aluControlE = ALU_ADD; #1;
    check("unlisted code", XLEN'(branchTakenE), XLEN'(0));
    @(negedge clk); aluControlE = BR_BEQ; branchE = 1'b0; #1;
    check("branchE low", XLEN'(branchTakenE), XLEN'(0));
    @(negedge clk); branchE = 1'b0;

    // Multiply and divide, including back-to-back issue
    md_op("MULH min*min", MD_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1);
    md_op("MUL 7*-3", MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1);
    md_op("MULHU max*max", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
    md_op("MULHSU -1*max", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    md_op("DIV -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, XLEN + 1);
    go_idle();
    md_op("REM -7%2", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, XLEN + 1);
    md_op("DIVU 100/7", MD_DIVU, 32'd100, 32'd7, 32'd14, XLEN + 1);
    md_op("REMU 100%7", MD_REMU, 32'd100, 32'd7, 32'd2, XLEN + 1);
    go_idle();
    md_op("DIV 5/0", MD_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_STALL);
    md_op("REM 5%0", MD_REM, 32'd5, 32'd0, 32'd5, SPECIAL_STALL);
    md_op("REM -5%0", MD_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPECIAL_STALL);
    md_op("DIV min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_STALL);
    md_op("REM min%-1", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPECIAL_STALL);
    go_idle();

    // Flush mid-divide
    @(negedge clk);
    rd1E = 32'd1000; rd2E = 32'd3; mdOpE = MD_DIV; mdValidE = 1'b1; flushE = 1'b0;
    repeat (10) @(negedge clk);
    flushE = 1'b1; #1;
    check("flush cycle stall", XLEN'(stallMD), XLEN'(1));
    @(negedge clk); flushE = 1'b0; mdValidE = 1'b0; #1;
    check("after flush stallMD", XLEN'(stallMD), XLEN'(0));
    check("after flush mdBusy", XLEN'(mdBusy), XLEN'(0));
    $display("flush at T+10 of DIV stallMD=%0d mdBusy=%0d", stallMD, mdBusy);

    // Asynchronous reset mid-divide
    @(negedge clk);
    rd1E = 32'd1000; rd2E = 32'd3; mdOpE = MD_DIVU; mdValidE = 1'b1;
    repeat (5) @(negedge clk);
    mdValidE = 1'b0; #1;
    check("mid-div stall held", XLEN'(stallMD), XLEN'(1));
    #1; rst = 1'b1; #1;
    check("async rst stallMD", XLEN'(stallMD), XLEN'(0));
    check("async rst mdBusy", XLEN'(mdBusy), XLEN'(0));
    $display("async reset mid-DIV stallMD=%0d mdBusy=%0d", stallMD, mdBusy);
    @(negedge clk); rst = 1'b0;
    md_op("MUL after rst", MD_MUL, 32'd12, 32'd11, 32'd132, 1);
    go_idle();
    @(negedge clk); #1;
    check("idle after MUL", XLEN'(mdBusy), XLEN'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
